// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready pipeline register with skid buffer; in_rdy is a flop.
// Optional synchronous drop of all entries via `flush` when PIPE_SKID_REG_FLUSH_EN is defined.
module pipe_skid_reg #(
  parameter int unsigned p_nbits = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg
`ifdef PIPE_SKID_REG_FLUSH_EN
  ,
  input  logic               flush
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [p_nbits-1:0] head_q, head_d;
  logic [p_nbits-1:0] skid_q, skid_d;
  logic               in_rdy_q, in_rdy_d;
  logic               out_val_q, out_val_d;
  logic               in_fire, out_fire;
  logic               flush_w;

`ifdef PIPE_SKID_REG_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_fire  = in_val & in_rdy_q;
  assign out_fire = out_val_q & out_rdy;

  // Next-state and datapath; flush overrides every transition
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = HALF;
          head_d  = in_msg;
        end
      end
      HALF: begin
        if (in_fire && out_fire) begin
          head_d = in_msg;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_msg;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = HALF;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_w) begin
      state_d = EMPTY;
    end
    in_rdy_d  = (state_d != FULL);
    out_val_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      in_rdy_q  <= 1'b0;
      out_val_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      in_rdy_q  <= in_rdy_d;
      out_val_q <= out_val_d;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_val = out_val_q;
  assign out_msg = head_q;

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Two-entry valid/ready pipeline register with a skid buffer, parameterised on message width. It sits directly downstream of the stage-boundary select muxes in the TinyRV1 datapath. For example, it captures the selected next-PC or writeback value and hands it to the next stage. It provides full throughput (one transfer per cycle) and breaks the combinational ready path between stages.

## Interface
- p_nbits, 32, width of the message carried through the register

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_val  input  1  upstream message valid
- in_rdy  output  1  block can accept a message this cycle (registered)
- in_msg  input  p_nbits  upstream message, typically the select-mux output
- out_val  output  1  head entry valid
- out_rdy  input  1  downstream accepts head this cycle
- out_msg  output  p_nbits  head entry message
- flush  input  1  drop all held entries; present only with PIPE_SKID_REG_FLUSH_EN

## Operation
- Reset: one clock, `clk`. Reset is asynchronous and active-low, named `rst_n`.
- Storage: head register (drives out_msg) and skid register; 2-bit state.
- Fire definitions:
  - in_fire = in_val & in_rdy
  - out_fire = out_val & out_rdy
- States: EMPTY (0 entries), HALF (1 entry in head), FULL (head + skid).
- Transitions from EMPTY:
  - in_fire → HALF, head ← in_msg
- Transitions from HALF:
  - in_fire & out_fire → HALF, head ← in_msg
  - in_fire only → FULL, skid ← in_msg
  - out_fire only → EMPTY
  - neither → HALF
- Transitions from FULL:
  - out_fire → HALF, head ← skid
  - otherwise → FULL
  - in_fire is impossible in FULL because in_rdy = 0.
- Outputs:
  - out_val = (state != EMPTY)
  - out_msg = head
- in_rdy is a flop, next value = (next_state != FULL). There is no combinational path from out_rdy to in_rdy.
- FIFO order is strict; no message is duplicated or dropped except by flush.
- head and skid are not cleared when entries leave. Their contents are don't-care when the entry is invalid, but out_msg must not change while out_val & !out_rdy.
- in_msg is sampled only on in_fire. in_val without in_rdy has no effect.

## Timing
- Reset values (asserted asynchronously while rst_n low):
  - state = EMPTY
  - out_val = 0
  - out_msg = 0
  - skid = 0
  - in_rdy = 0
- First rising edge after rst_n rises sets in_rdy = 1.
- Latency: in_fire at edge N → out_val = 1, out_msg = that message after edge N.
- Throughput: 1 message/cycle sustained when out_rdy held 1 (state stays HALF).
- Backpressure: out_rdy drops with one entry held → accepts one more (skid), then in_rdy = 0 after the next edge.
- FULL and out_rdy returns:
  - after one out_fire, in_rdy = 1 again the following cycle;
  - the skid value becomes head the same edge.
- Reset mid-operation: all entries discarded immediately; no out_val glitch after rst_n release.

## Configuration
- PIPE_SKID_REG_FLUSH_EN defined:
  - `flush` port exists.
  - flush = 1 at an edge forces state → EMPTY and next in_rdy = 1.
  - Flush takes priority over simultaneous in_fire/out_fire. The accepted input is dropped; the out_fire is still counted as consumed by downstream.
  - out_val = 0 the cycle after.
- PIPE_SKID_REG_FLUSH_EN undefined:
  - no `flush` port; behaviour identical to flush tied 0.

## Test plan
- Reset release, in_val = 0 → out_val = 0, out_msg = 0, in_rdy = 0 until first edge, then 1.
- Stream 0x100, 0x104, 0x108 with out_rdy = 1 → each appears one cycle after accept; in_rdy stays 1; state HALF throughout.
- Hold out_rdy = 0, send 0xA then 0xB:
  - in_rdy = 0 after second accept; out_msg stays 0xA.
  - Raise out_rdy → outputs 0xA, then 0xB; in_rdy = 1 one cycle after first out_fire.
- FULL with in_val = 1, in_msg = 0xC held → 0xC not taken until in_rdy = 1; final order 0xA, 0xB, 0xC.
- Assert rst_n = 0 mid-cycle while FULL → out_val = 0, in_rdy = 0 immediately without clock; no stale 0xA/0xB after release.
- (FLUSH_EN) In FULL, pulse flush with in_val = 1, in_msg = 0xD → next cycle out_val = 0, in_rdy = 1, and 0xD is never output.
